xgemac_rx_reader: RTL
=====================

XGEMAC_RX_READER -- requirements
Module: xgemac_rx_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output beat buffer depth (power of two, >=4).
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1518, meaning largest legal frame length in bytes.
REQ-003 clk_156m25  in  1  sole clock; all logic rising-edge.
REQ-004 reset_156m25_n  in  1  reset, synchronous, active-low.
REQ-005 pkt_rx_avail  in  1  MAC holds at least one frame.
REQ-006 pkt_rx_ren  out  1  read enable to MAC; one beat returned per ren cycle, one cycle later.
REQ-007 pkt_rx_data  in  64  MAC beat data.
REQ-008 pkt_rx_val  in  1  beat valid.
REQ-009 pkt_rx_sop / pkt_rx_eop  in  1 each  first / last beat of frame.
REQ-010 pkt_rx_mod  in  3  valid bytes on eop beat; 0 means 8.
REQ-011 pkt_rx_err  in  1  MAC frame error, qualified by eop.
REQ-012 out_data  out  64; out_sop, out_eop, out_err  out  1 each; out_mod  out  3  downstream beat.
REQ-013 out_valid  out  1 / out_ready  in  1  downstream handshake; transfer when both high.
REQ-014 frame_cnt  out  32  frames delivered; err_cnt  out  16  frames delivered with out_err; proto_cnt  out  16  protocol violations.

Function
REQ-015 FSM states IDLE, READ, WAIT_EOP; IDLE->READ when pkt_rx_avail=1 and FIFO free slots >=2.
REQ-016 In READ, pkt_rx_ren SHALL be 1 only while free slots minus in-flight beats >=2; otherwise 0 (pause, stay in READ).
REQ-017 On accepted beat with eop, pkt_rx_ren SHALL be 0 the next cycle and FSM -> WAIT_EOP for one cycle to absorb latency, then IDLE.
REQ-018 Every beat with pkt_rx_val=1 SHALL be written to FIFO; FIFO never overflows (credit rule guarantees); overflow is an assertion failure.
REQ-019 Frame byte counter 16-bit, saturating at 0xFFFF: +8 per non-eop beat, +(mod==0?8:mod) on eop beat; cleared at sop.
REQ-020 out_err on eop beat SHALL equal pkt_rx_err OR byte count > MAX_FRAME_BYTES OR protocol flag of the frame.
REQ-021 val=1 with sop=0 outside a frame: beat discarded, proto_cnt+1.
REQ-022 sop=1 inside a frame: proto_cnt+1, beat passed with out_sop cleared, protocol flag set, byte count continues.
REQ-023 out_valid SHALL be 1 whenever FIFO non-empty; out_* stable while out_valid=1 and out_ready=0.
REQ-024 Latency: beat on pkt_rx_* at cycle N SHALL be presentable on out_* at cycle N+1 if FIFO was empty.
REQ-025 Simultaneous FIFO write and read SHALL keep occupancy unchanged, including when full or empty.
REQ-026 frame_cnt SHALL increment on out_eop transfer; err_cnt also if out_err; all counters wrap for frame_cnt, saturate for err_cnt/proto_cnt.

Reset
REQ-027 With reset_156m25_n=0 at a clock edge: FSM=IDLE, pkt_rx_ren=0, FIFO empty, out_valid=0, out_data/out_mod=0, out_sop/out_eop/out_err=0, all counters 0.
REQ-028 Reset mid-frame SHALL discard buffered beats; next frame accepted only from a sop beat.

Structure
REQ-029 State enum, beat struct (data, sop, eop, mod, err) and MAX_FRAME_BYTES default SHALL live in shared package xgemac_rtl_pkg.
REQ-030 FIFO SHALL be sub-module xgemac_sync_fifo (parameterized width/depth, full/empty/count).

Verification
REQ-031 Single 64-byte frame (8 beats, mod=0), out_ready=1 -> 8 out beats, sop on 1st, eop on 8th, out_err=0, frame_cnt=1.
REQ-032 61-byte frame (eop mod=5) with out_ready low 20 cycles -> pkt_rx_ren drops when free<2, no loss, byte count 61, out_mod=5.
REQ-033 1600-byte frame (200 beats) -> out_err=1 on eop, err_cnt=1, frame_cnt=1.
REQ-034 Stray val without sop, then sop mid-frame -> proto_cnt=2, stray beat absent, second frame eop has out_err=1.
REQ-035 Reset asserted at beat 3 of 8 -> outputs per REQ-027 next cycle; subsequent clean 16-byte frame delivered intact, frame_cnt=1.
REQ-036 Back-to-back frames with pkt_rx_avail held high -> ren gap of exactly the WAIT_EOP cycle, both frames delivered in order.

Source files
------------

// File: rtl/xgemac_rx_reader_pkg.sv
// xgemac_rtl_pkg: shared state, beat type and frame-size default for the XGEMAC receive reader
package xgemac_rtl_pkg;
    localparam int MAX_FRAME_BYTES_DEF = 1518;
    typedef enum logic [1:0] {IDLE, READ, WAIT_EOP} rx_state_e;
    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } beat_t;
    function automatic logic [3:0] eop_bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
    endfunction
endpackage

// File: rtl/xgemac_rx_reader_if.sv
// xgemac_rx_reader_if: MAC receive-side bus and downstream beat stream
interface xgemac_mac_rx_if;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    modport master (output pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err,
                    input pkt_rx_ren);
    modport slave (input pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err,
                   output pkt_rx_ren);
endinterface

interface xgemac_beat_if;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [2:0]  out_mod;
    logic        out_valid;
    logic        out_ready;
    modport master (output out_data, out_sop, out_eop, out_err, out_mod, out_valid, input out_ready);
    modport slave (input out_data, out_sop, out_eop, out_err, out_mod, out_valid, output out_ready);
endinterface

// File: rtl/xgemac_rx_reader_fifo.sv
// xgemac_sync_fifo: synchronous beat FIFO with occupancy count; a write while full lands only alongside a read
module xgemac_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   rd_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             wr_ok, rd_ok;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign rd_ok   = rd_i && !empty_o;
    assign wr_ok   = wr_i && (!full_o || rd_ok);
    assign rdata_o = mem_q[rp_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_ok) wp_q <= wp_q + 1'b1;
            if (rd_ok) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/xgemac_rx_reader.sv
// xgemac_rx_reader: pulls frames from the XGEMAC receive port under FIFO credit, tags framing/size errors,
// and presents them as a ready/valid beat stream with delivery and protocol counters
module xgemac_rx_reader
    import xgemac_rtl_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
    input  logic          clk_156m25,
    input  logic          reset_156m25_n,
    xgemac_mac_rx_if.slave mac,
    xgemac_beat_if.master  dn,
    output logic [31:0]   frame_cnt,
    output logic [15:0]   err_cnt,
    output logic [15:0]   proto_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    rx_state_e    state_q;
    logic         ren_q, in_frame_q, proto_q, proto_d;
    logic [15:0]  bytes_q, bytes_d, err_cnt_q, proto_cnt_q;
    logic [16:0]  bytes_sum;
    logic [31:0]  frame_cnt_q;
    logic         start, stray, resop, eop_in, credit_ok;
    logic         fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt, cnt_nxt;
    beat_t        wr_beat, rd_beat, out_beat;
    assign start   = mac.pkt_rx_val && mac.pkt_rx_sop && !in_frame_q;
    assign stray   = mac.pkt_rx_val && !mac.pkt_rx_sop && !in_frame_q;
    assign resop   = mac.pkt_rx_val && mac.pkt_rx_sop && in_frame_q;
    assign eop_in  = mac.pkt_rx_val && mac.pkt_rx_eop;
    assign fifo_wr = mac.pkt_rx_val && !stray;
    assign fifo_rd = !fifo_empty && dn.out_ready;
    assign bytes_sum = {1'b0, start ? 16'd0 : bytes_q}
                     + 17'(mac.pkt_rx_eop ? eop_bytes(mac.pkt_rx_mod) : 4'd8);
    assign bytes_d = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
    assign proto_d = !start && (proto_q || resop);
    assign wr_beat = '{data: mac.pkt_rx_data, sop: start, eop: mac.pkt_rx_eop,
                       mod: mac.pkt_rx_eop ? mac.pkt_rx_mod : 3'd0,
                       err: mac.pkt_rx_eop && (mac.pkt_rx_err || 32'(bytes_d) > 32'(MAX_FRAME_BYTES) || proto_d)};
    // Credit counts the occupancy after this edge plus the beat already requested for next cycle
    assign cnt_nxt   = fifo_cnt + CW'(fifo_wr) - CW'(fifo_rd);
    assign credit_ok = 32'(cnt_nxt) + 32'(ren_q) + 32'd2 <= 32'(FIFO_DEPTH);
    xgemac_sync_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_156m25),
        .rst_n   (reset_156m25_n),
        .wr_i    (fifo_wr),
        .wdata_i (wr_beat),
        .rd_i    (fifo_rd),
        .rdata_o (rd_beat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );
    assign out_beat     = fifo_empty ? '0 : rd_beat;
    assign dn.out_valid = !fifo_empty;
    assign dn.out_data  = out_beat.data;
    assign dn.out_sop   = out_beat.sop;
    assign dn.out_eop   = out_beat.eop;
    assign dn.out_mod   = out_beat.mod;
    assign dn.out_err   = out_beat.err;
    assign mac.pkt_rx_ren = ren_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign proto_cnt    = proto_cnt_q;
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
        end else begin
            case (state_q)
                READ: begin
                    state_q <= eop_in ? WAIT_EOP : READ;
                    ren_q   <= !eop_in && credit_ok;
                end
                // WAIT_EOP absorbs the beat requested alongside eop, then resumes directly if more is queued
                default: begin
                    state_q <= (mac.pkt_rx_avail && credit_ok) ? READ : IDLE;
                    ren_q   <= mac.pkt_rx_avail && credit_ok;
                end
            endcase
        end
    end
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            in_frame_q  <= 1'b0;
            proto_q     <= 1'b0;
            bytes_q     <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            proto_cnt_q <= '0;
        end else begin
            if (fifo_wr) begin
                in_frame_q <= !mac.pkt_rx_eop;
                proto_q    <= proto_d;
                bytes_q    <= bytes_d;
            end
            if (stray || resop) proto_cnt_q <= proto_cnt_q + {15'd0, proto_cnt_q != 16'hFFFF};
            if (fifo_rd && rd_beat.eop) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
                if (rd_beat.err) err_cnt_q <= err_cnt_q + {15'd0, err_cnt_q != 16'hFFFF};
            end
        end
    end
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25_n) assert (!(fifo_wr && fifo_full && !fifo_rd));
    end
endmodule
